// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator: runs each beat of a valid/ready command as a
// single read/write cycle and returns one response per beat.
module wb_cmd_master #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned SW      = DW / 8,
    parameter int unsigned LW      = 8,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic          wb_clk_i,
    input  logic          wb_resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [SW-1:0] cmd_sel,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] wr_data,
    output logic          wr_adv,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_last,
    output logic          busy,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [SW-1:0] wb_sel_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [LW-1:0] beats_q, beats_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          cyc_q, cyc_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_last_q, rsp_last_d;

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            beats_q     <= '0;
            wait_q      <= '0;
            cyc_q       <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            beats_q     <= beats_d;
            wait_q      <= wait_d;
            cyc_q       <= cyc_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        beats_d     = beats_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_last_d  = 1'b0;
        wr_adv      = 1'b0;

        case (state_q)
            IDLE: begin
                // ready_q gates acceptance so nothing is taken in the first cycle after reset
                if (cmd_valid && ready_q) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_addr;
                    sel_d   = cmd_sel;
                    beats_d = (cmd_len == '0) ? LW'(1) : cmd_len;
                    dat_d   = cmd_we ? wr_data : '0;
                    wr_adv  = cmd_we;
                    wait_d  = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wb_err_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    state_d     = IDLE;
                end else if (wb_ack_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : wb_dat_i;
                    beats_d     = beats_q - LW'(1);
                    if (beats_q == LW'(1)) begin
                        rsp_last_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        adr_d   = adr_q + AW'(SW);
                        state_d = GAP;
                    end
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            GAP: begin
                wait_d  = '0;
                state_d = ACCESS;
                if (we_q) begin
                    dat_d  = wr_data;
                    wr_adv = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus and handshake outputs are registered from the next state so they
        // change on the same edge as the FSM and reset cleanly.
        cyc_d   = (state_d == ACCESS);
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_sel_o  = sel_q;
    assign wb_dat_o  = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: bus timing, responses, timeout, error and reset abort.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        wb_resetn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_sel = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_adv;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_last;
    logic        busy;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    int errs = 0;
    int checks = 0;
    int wa_cnt = 0;
    int rsp_cnt = 0;
    int s0, s1;

    wb_cmd_master #(.AW(32), .DW(32), .LW(8), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_resetn(wb_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_adv(wr_adv),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_last(rsp_last), .busy(busy),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_adv)    wa_cnt  <= wa_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Entered at a negedge with the FSM idle; returns at the negedge of the first ACCESS cycle.
    task automatic start_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                             input logic [7:0] len, input logic [31:0] wd, input string tag);
        chk({tag, "_ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = adr;
        cmd_sel   = sel;
        cmd_len   = len;
        wr_data   = wd;
        #1;
        chk({tag, "_wradv_acc"}, wr_adv, we);
        step();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_0000;
        wr_data   = 32'h1111_1111;
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_notready"}, cmd_ready, 1'b0);
    endtask

    // Slave holds off for n stb cycles, terminating on the last with (a, e).
    task automatic beat(input int n, input logic a, input logic e, input logic [31:0] rd,
                        input logic [31:0] adr, input logic [3:0] sel, input logic we,
                        input logic [31:0] dat, input string tag);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_cyc"}, wb_cyc_o, 1'b1);
            chk({tag, "_stb"}, wb_stb_o, 1'b1);
            chk({tag, "_adr"}, wb_adr_o, adr);
            chk({tag, "_sel"}, wb_sel_o, sel);
            chk({tag, "_we"}, wb_we_o, we);
            chk({tag, "_dat"}, wb_dat_o, dat);
            chk({tag, "_norsp"}, rsp_valid, 1'b0);
            if (i == n - 1) begin
                wb_ack_i = a;
                wb_err_i = e;
                wb_dat_i = rd;
            end
            step();
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0BAD_F00D;
    endtask

    task automatic chk_rsp(input logic [31:0] rd, input logic err, input logic last, input string tag);
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_cyc_low"}, wb_cyc_o, 1'b0);
        chk({tag, "_stb_low"}, wb_stb_o, 1'b0);
        chk({tag, "_rdata"}, rsp_rdata, rd);
        chk({tag, "_err"}, rsp_err, err);
        chk({tag, "_last"}, rsp_last, last);
    endtask

    initial begin
        #2 wb_resetn = 1'b0;
        step();
        step();
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp", rsp_valid, 1'b0);
        chk("rst_adr", wb_adr_o, 32'h0);
        wb_resetn = 1'b1;
        #1 chk("rel_ready_before_edge", cmd_ready, 1'b0);
        step();
        chk("rel_ready_after_edge", cmd_ready, 1'b1);

        // Single write, acked on the third stb cycle
        s0 = wa_cnt;
        start_cmd(1'b1, 32'h100, 4'hF, 8'd1, 32'hDEAD_BEEF, "t1");
        beat(3, 1'b1, 1'b0, 32'h5555_5555, 32'h100, 4'hF, 1'b1, 32'hDEAD_BEEF, "t1b");
        chk_rsp(32'h0, 1'b0, 1'b1, "t1r");
        chk("t1_ready_again", cmd_ready, 1'b1);
        chk("t1_idle", busy, 1'b0);
        step();
        chk("t1_rsp_pulse", rsp_valid, 1'b0);
        chk("t1_wradv_cnt", 64'(wa_cnt - s0), 64'd1);

        // Four-beat read from 0x1FC, one idle bus cycle between beats
        s1 = rsp_cnt;
        start_cmd(1'b0, 32'h1FC, 4'hF, 8'd4, 32'h0, "t2");
        beat(1, 1'b1, 1'b0, 32'hA0, 32'h1FC, 4'hF, 1'b0, 32'h0, "t2b0");
        chk_rsp(32'hA0, 1'b0, 1'b0, "t2r0");
        chk("t2_gap_wradv", wr_adv, 1'b0);
        step();
        beat(1, 1'b1, 1'b0, 32'hA1, 32'h200, 4'hF, 1'b0, 32'h0, "t2b1");
        chk_rsp(32'hA1, 1'b0, 1'b0, "t2r1");
        step();
        beat(1, 1'b1, 1'b0, 32'hA2, 32'h204, 4'hF, 1'b0, 32'h0, "t2b2");
        chk_rsp(32'hA2, 1'b0, 1'b0, "t2r2");
        step();
        beat(1, 1'b1, 1'b0, 32'hA3, 32'h208, 4'hF, 1'b0, 32'h0, "t2b3");
        chk_rsp(32'hA3, 1'b0, 1'b1, "t2r3");
        step();
        chk("t2_rsp_cnt", 64'(rsp_cnt - s1), 64'd4);

        // Read never terminated by the slave: timeout after 16 stb cycles
        start_cmd(1'b0, 32'h300, 4'h3, 8'd1, 32'h0, "t3");
        wb_dat_i = 32'h7777_7777;
        beat(16, 1'b0, 1'b0, 32'h7777_7777, 32'h300, 4'h3, 1'b0, 32'h0, "t3b");
        chk_rsp(32'h0, 1'b1, 1'b1, "t3r");

        // Accepted in the same cycle as the timeout response; err beats ack on beat 2
        s0 = wa_cnt;
        start_cmd(1'b1, 32'h400, 4'h3, 8'd3, 32'hCAFE_0001, "t4");
        beat(1, 1'b1, 1'b0, 32'h0, 32'h400, 4'h3, 1'b1, 32'hCAFE_0001, "t4b0");
        chk_rsp(32'h0, 1'b0, 1'b0, "t4r0");
        wr_data = 32'hCAFE_0002;
        #1 chk("t4_gap_wradv", wr_adv, 1'b1);
        step();
        wr_data = 32'hCAFE_0003;
        beat(2, 1'b1, 1'b1, 32'h0, 32'h404, 4'h3, 1'b1, 32'hCAFE_0002, "t4b1");
        chk_rsp(32'h0, 1'b1, 1'b1, "t4r1");
        step();
        chk("t4_no_beat3_cyc", wb_cyc_o, 1'b0);
        step();
        chk("t4_no_beat3_cyc2", wb_cyc_o, 1'b0);
        chk("t4_idle", busy, 1'b0);
        chk("t4_wradv_cnt", 64'(wa_cnt - s0), 64'd2);

        // Reset asserted in the middle of an ACCESS cycle
        start_cmd(1'b1, 32'h500, 4'hC, 8'd2, 32'h1234_5678, "t5");
        chk("t5_cyc_up", wb_cyc_o, 1'b1);
        s1 = rsp_cnt;
        #2 wb_resetn = 1'b0;
        #1;
        chk("t5_cyc", wb_cyc_o, 1'b0);
        chk("t5_stb", wb_stb_o, 1'b0);
        chk("t5_we", wb_we_o, 1'b0);
        chk("t5_sel", wb_sel_o, 4'h0);
        chk("t5_adr", wb_adr_o, 32'h0);
        chk("t5_dat", wb_dat_o, 32'h0);
        chk("t5_busy", busy, 1'b0);
        step();
        chk("t5_norsp", rsp_valid, 1'b0);
        step();
        wb_resetn = 1'b1;
        #1 chk("t5_ready_before_edge", cmd_ready, 1'b0);
        step();
        chk("t5_ready_after_edge", cmd_ready, 1'b1);
        chk("t5_rsp_cnt", 64'(rsp_cnt - s1), 64'd0);

        // Address wrap, then a zero-length command
        start_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 8'd2, 32'h0, "t6");
        beat(1, 1'b1, 1'b0, 32'hB0, 32'hFFFF_FFFC, 4'hF, 1'b0, 32'h0, "t6b0");
        chk_rsp(32'hB0, 1'b0, 1'b0, "t6r0");
        step();
        beat(1, 1'b1, 1'b0, 32'hB1, 32'h0, 4'hF, 1'b0, 32'h0, "t6b1");
        chk_rsp(32'hB1, 1'b0, 1'b1, "t6r1");
        step();
        s1 = rsp_cnt;
        start_cmd(1'b0, 32'h40, 4'hF, 8'd0, 32'h0, "t7");
        beat(1, 1'b1, 1'b0, 32'hC0, 32'h40, 4'hF, 1'b0, 32'h0, "t7b");
        chk_rsp(32'hC0, 1'b0, 1'b1, "t7r");
        step();
        step();
        chk("t7_single_beat", wb_cyc_o, 1'b0);
        chk("t7_rsp_cnt", 64'(rsp_cnt - s1), 64'd1);

        // Termination strobes while idle are ignored
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        step();
        chk("idle_ack_ignored", rsp_valid, 1'b0);
        chk("idle_ready", cmd_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
